// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, widths and request record for the datamem arbiter
package mem_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_WIDTH = 128;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef struct packed {
    logic we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: two-way round-robin selector; ptr names the input that wins a tie and moves to the loser on every take
module rr_pick #(
  parameter bit INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic take,
  output logic any,
  output logic pick_b
);
  logic ptr;
  assign any = a | b;
  assign pick_b = b & (~a | ptr);
  always_ff @(posedge clk) begin
    if (rst) ptr <= INIT;
    else if (take && any) ptr <= ~pick_b;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide datamem between the instruction port (I) and the data port (D)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int TIMEOUT = 255,
  parameter bit D_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_req,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [LINE_WIDTH-1:0] mem_writedata,
  input  logic [LINE_WIDTH-1:0] mem_readdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  grant_d,
  output logic                  timeout_err
);
  import mem_pkg::*;
  localparam int CW = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  arb_state_t state;
  mem_req_t bus, i_cmd, d_cmd;
  logic [CW-1:0] wait_cnt;
  logic any, pick_d, done;
  assign i_cmd = {i_we, i_addr, i_wdata};
  assign d_cmd = {d_we, d_addr, d_wdata};
  rr_pick #(.INIT(D_FIRST)) u_pick (
    .clk(clk),
    .rst(rst),
    .a(i_req),
    .b(d_req),
    .take(state == IDLE),
    .any(any),
    .pick_b(pick_d)
  );
  // a reset in the completion cycle abandons the transaction, so it never reports ready
  assign done = mem_ready & ~rst & (state != IDLE);
  assign i_ready = done & (state == SERVE_I);
  assign d_ready = done & (state == SERVE_D);
  assign i_rdata = i_ready ? mem_readdata : '0;
  assign d_rdata = d_ready ? mem_readdata : '0;
  assign WriteEnable = bus.we;
  assign memory_address = bus.addr;
  assign mem_writedata = bus.wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus <= '0;
      mem_req <= 1'b0;
      busy <= 1'b0;
      grant_d <= 1'b0;
      wait_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (any) begin
            state <= pick_d ? SERVE_D : SERVE_I;
            bus <= pick_d ? d_cmd : i_cmd;
            mem_req <= 1'b1;
            busy <= 1'b1;
            grant_d <= pick_d;
          end
        end
        default: begin
          if (mem_ready) begin
            state <= IDLE;
            mem_req <= 1'b0;
            busy <= 1'b0;
            grant_d <= 1'b0;
            wait_cnt <= '0;
          end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (TIMEOUT != 0 && wait_cnt + 1'b1 == LIMIT) timeout_err <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 4;
  localparam logic [LW-1:0] BEEF = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
  localparam logic [LW-1:0] A5 = {16{8'hA5}};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 1'b0, i_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] i_wdata = '0, d_wdata = '0;
  logic [LW-1:0] mem_readdata = '0;
  logic mem_ready = 1'b0;
  logic [LW-1:0] i_rdata, d_rdata, mem_writedata;
  logic [AW-1:0] memory_address;
  logic i_ready, d_ready, mem_req, WriteEnable, busy, grant_d, timeout_err;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO), .D_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .WriteEnable(WriteEnable), .memory_address(memory_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ready(mem_ready),
    .busy(busy), .grant_d(grant_d), .timeout_err(timeout_err)
  );
  int owner;
  bit prio_d, m_mreq, m_err, exp_i_ready, exp_d_ready;
  logic m_we;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, got_i_rdata, got_d_rdata;
  int m_wait;
  int checks = 0, errors = 0;
  logic [LW-1:0] store [logic [AW-1:0]];
  int mem_mode = 0, fix_lat = -1, resp_cnt = -1, resp_lat = 0;
  bit force_ready = 1'b0;
  int n;
  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    owner = -1;
    prio_d = 1'b1;
    m_mreq = 1'b0;
    m_we = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_wait = 0;
    m_err = 1'b0;
  endtask
  task automatic respond();
    mem_ready = 1'b0;
    mem_readdata = rnd_line();
    if (!mem_req) resp_cnt = -1;
    else if (mem_mode == 0) begin
      if (resp_cnt < 0) begin
        resp_cnt = 0;
        resp_lat = fix_lat >= 0 ? fix_lat : ($urandom_range(0, 19) == 0 ? 6 : int'($urandom_range(0, 3)));
      end
      if (resp_cnt == resp_lat) begin
        mem_ready = 1'b1;
        resp_cnt = -1;
        mem_readdata = store.exists(memory_address) ? store[memory_address] : {4{memory_address}};
        if (WriteEnable) store[memory_address] = mem_writedata;
      end else resp_cnt++;
    end
    if (!mem_req && mem_mode == 0 && fix_lat < 0 && $urandom_range(0, 7) == 0) mem_ready = 1'b1;
    if (force_ready) mem_ready = 1'b1;
  endtask
  task automatic tick();
    respond();
    #1;
    exp_i_ready = owner == 0 && mem_ready && !rst;
    exp_d_ready = owner == 1 && mem_ready && !rst;
    chk("mem_req", mem_req, m_mreq);
    chk("WriteEnable", WriteEnable, m_we);
    chk("memory_address", memory_address, m_addr);
    chk("mem_writedata", mem_writedata, m_wdata);
    chk("i_ready", i_ready, exp_i_ready);
    chk("d_ready", d_ready, exp_d_ready);
    chk("i_rdata", i_rdata, exp_i_ready ? mem_readdata : '0);
    chk("d_rdata", d_rdata, exp_d_ready ? mem_readdata : '0);
    chk("busy", busy, owner >= 0);
    chk("grant_d", grant_d, owner == 1);
    chk("timeout_err", timeout_err, m_err);
    got_i_rdata = i_rdata;
    got_d_rdata = d_rdata;
    if (rst) model_reset();
    else if (owner < 0) begin
      m_wait = 0;
      if (i_req || d_req) begin
        owner = (i_req && d_req) ? int'(prio_d) : int'(d_req);
        prio_d = owner == 0;
        m_mreq = 1'b1;
        m_we = owner == 1 ? d_we : i_we;
        m_addr = owner == 1 ? d_addr : i_addr;
        m_wdata = owner == 1 ? d_wdata : i_wdata;
      end
    end else if (mem_ready) begin
      owner = -1;
      m_mreq = 1'b0;
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait >= TO) m_err = 1'b1;
    end
    @(negedge clk);
  endtask
  task automatic wait_ready(input bit port_d, input string name, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(port_d ? exp_d_ready : exp_i_ready) && cnt < 50);
    checks++;
    if (!(port_d ? exp_d_ready : exp_i_ready)) begin
      errors++;
      $display("FAIL %s: no ready within %0d cycles", name, cnt);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    @(negedge clk);
    tick();
    rst = 1'b0;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", timeout_err, 1'b0);
    chk("reset_addr", memory_address, '0);
    store[32'h40] = BEEF;
    fix_lat = 2;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h40;
    tick();
    chk("rd_mem_req", mem_req, 1'b1);
    chk("rd_addr", memory_address, 32'h40);
    wait_ready(1'b0, "rd_ready", n);
    chk("rd_latency", n, 3);
    chk("rd_data", got_i_rdata, BEEF);
    i_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fix_lat = 1;
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    tick();
    chk("tie1_first_d", grant_d, 1'b1);
    wait_ready(1'b1, "tie1_d_ready", n);
    d_req = 1'b0;
    tick();
    chk("tie1_then_i", grant_d, 1'b0);
    chk("tie1_then_busy", busy, 1'b1);
    wait_ready(1'b0, "tie1_i_ready", n);
    i_req = 1'b0;
    tick();
    i_req = 1'b1; d_req = 1'b1;
    tick();
    chk("tie2_first_d", grant_d, 1'b1);
    wait_ready(1'b1, "tie2_d_ready", n);
    d_req = 1'b0;
    tick();
    chk("tie2_then_i", grant_d, 1'b0);
    wait_ready(1'b0, "tie2_i_ready", n);
    i_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = A5;
    tick();
    chk("wr_we", WriteEnable, 1'b1);
    chk("wr_data", mem_writedata, A5);
    wait_ready(1'b1, "wr_ready", n);
    d_req = 1'b0; d_we = 1'b0;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h100;
    tick();
    wait_ready(1'b0, "rdback_ready", n);
    chk("rdback_data", got_i_rdata, A5);
    i_req = 1'b0;
    tick();
    fix_lat = 3;
    d_req = 1'b1; d_addr = 32'h200;
    tick();
    d_addr = 32'h300; d_wdata = rnd_line();
    tick();
    chk("hold_addr_1", memory_address, 32'h200);
    tick();
    chk("hold_addr_2", memory_address, 32'h200);
    wait_ready(1'b1, "hold_ready", n);
    d_req = 1'b0;
    tick();
    mem_mode = 1;
    i_req = 1'b1; i_addr = 32'h80;
    tick();
    repeat (3) tick();
    chk("wd_after_3", timeout_err, 1'b0);
    tick();
    chk("wd_after_4", timeout_err, 1'b1);
    repeat (3) tick();
    chk("wd_sticky", timeout_err, 1'b1);
    chk("wd_still_req", mem_req, 1'b1);
    rst = 1'b1; i_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("wd_rst_err", timeout_err, 1'b0);
    chk("wd_rst_req", mem_req, 1'b0);
    mem_mode = 0;
    fix_lat = 100;
    i_req = 1'b1; i_addr = 32'h40;
    tick();
    rst = 1'b1; force_ready = 1'b1;
    tick();
    rst = 1'b0; force_ready = 1'b0; i_req = 1'b0;
    tick();
    chk("rr_i_ready", i_ready, 1'b0);
    chk("rr_mem_req", mem_req, 1'b0);
    chk("rr_busy", busy, 1'b0);
    chk("rr_we", WriteEnable, 1'b0);
    fix_lat = 0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    tick();
    chk("rr_ptr_d_first", grant_d, 1'b1);
    wait_ready(1'b1, "rr_d_ready", n);
    d_req = 1'b0;
    tick();
    wait_ready(1'b0, "rr_i_ready_after", n);
    i_req = 1'b0;
    tick();
    fix_lat = -1;
    for (int c = 0; c < 4000; c++) begin
      if (exp_i_ready) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_we = 1'($urandom); i_addr = 32'($urandom_range(0, 15) << 4); i_wdata = rnd_line();
      end else if (i_req && $urandom_range(0, 9) == 0) begin
        i_addr = 32'($urandom_range(0, 15) << 4); i_wdata = rnd_line();
      end
      if (exp_d_ready) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 32'($urandom_range(0, 15) << 4); d_wdata = rnd_line();
      end else if (d_req && $urandom_range(0, 9) == 0) begin
        d_addr = 32'($urandom_range(0, 15) << 4); d_wdata = rnd_line();
      end
      rst = $urandom_range(0, 199) == 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
